// File: rtl/fetch_stage.sv
// RV32I fetch stage + IF/DEC register: PC, sync-read IMEM issue, 2-cycle fetch-to-decode latency.
// LW_STALL freezes PC and DEC; an in-flight instruction is parked in hold_ir so it is never re-read.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUB_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lw_stall,
  input  logic             if_flush,
  input  logic             dec_flush,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  output logic             imem_rden,
  input  logic [31:0]      imem_data,
  output logic [31:0]      dec_ir,
  output logic [31:0]      dec_pc,
  output logic             dec_valid,
  output logic [BUB_W-1:0] bubble_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, inf_pc, hold_ir, src_ir, target;
  logic        inf_valid, advance;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign imem_addr = redirect ? target : pc;
  assign imem_rden = !rst && (redirect || !lw_stall);
  assign src_ir    = (state == HOLD) ? hold_ir : imem_data;
  assign advance   = redirect || !lw_stall;

  // HOLD means the in-flight instruction already sits in hold_ir, not on imem_data.
  always_comb begin
    state_nxt = state;
    if (advance || if_flush)
      state_nxt = RUN;
    else if (state == RUN && inf_valid)
      state_nxt = HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inf_pc    <= '0;
      inf_valid <= 1'b0;
      hold_ir   <= '0;
      dec_ir    <= NOP;
      dec_pc    <= '0;
      dec_valid <= 1'b0;
    end else begin
      if (advance) begin
        pc        <= imem_addr + 32'd4;
        inf_pc    <= imem_addr;
        // A redirect's own fetch survives the flush that accompanies it.
        inf_valid <= redirect || !if_flush;
        if (inf_valid && !if_flush) begin
          dec_ir    <= src_ir;
          dec_pc    <= inf_pc;
          dec_valid <= 1'b1;
        end else begin
          dec_ir    <= NOP;
          dec_pc    <= '0;
          dec_valid <= 1'b0;
        end
      end else begin
        if (if_flush)
          inf_valid <= 1'b0;
        if (state == RUN && inf_valid)
          hold_ir <= imem_data;
      end
      if (dec_flush) begin
        dec_ir    <= NOP;
        dec_pc    <= '0;
        dec_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else if (!dec_valid && bubble_cnt != {BUB_W{1'b1}})
      bubble_cnt <= bubble_cnt + {{(BUB_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/DEC pipeline register of the pipelined RV32I core. Owns the PC, issues reads to the synchronous-read instruction memory, and delivers {instruction, PC, valid} to decode. Directly consumes the hazard unit's load-use stall and IF/DEC flush outputs, plus the branch/jump redirect resolved in EX. A holding buffer preserves an in-flight fetch across stalls, so no instruction is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- BUB_W, 16, width of the saturating bubble counter
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- LW_STALL  in  1  hold PC and IF/DEC register
- IF_FLUSH  in  1  squash the fetch currently returning from IMEM
- DEC_FLUSH  in  1  load a bubble into the IF/DEC register
- REDIRECT  in  1  taken branch/jump from EX
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored, forced 00
- IMEM_ADDR  out  32  fetch address; combinational
- IMEM_RDEN  out  1  read enable; data valid on IMEM_DATA the following cycle
- IMEM_DATA  in  32  instruction for the address issued last cycle
- DEC_IR  out  32  instruction to decode
- DEC_PC  out  32  PC of DEC_IR
- DEC_VALID  out  1  DEC_IR is a real instruction
- BUBBLE_CNT  out  BUB_W  cycles with DEC_VALID=0 since reset; saturating

## Operation
- Internal state:
  - PC: next address to fetch
  - INF_PC, INF_VALID: the fetch in flight, whose data arrives this cycle
  - HOLD_IR: holding buffer
  - FSM {RUN, HOLD}
- Issue address: IMEM_ADDR = REDIRECT ? {REDIRECT_PC[31:2],2'b00} : PC.
- IMEM_RDEN = !RST && (REDIRECT || !LW_STALL).
- Return data: src_ir = (state==HOLD) ? HOLD_IR : IMEM_DATA.
- Priority: RST > REDIRECT > LW_STALL > normal advance. Flushes are applied on top of whichever case is active.
- Normal advance (RUN or HOLD, no stall, no redirect):
  - PC <= PC+4
  - INF_PC <= PC; INF_VALID <= 1
  - DEC <= {src_ir, INF_PC, INF_VALID}
  - state <= RUN
- REDIRECT:
  - PC <= target+4
  - INF_PC <= target; INF_VALID <= 1
  - DEC advances as in normal advance
  - state <= RUN
  - The hazard unit asserts IF_FLUSH/DEC_FLUSH with it; this block does not infer flushes itself.
- LW_STALL (no redirect):
  - PC, INF_PC, INF_VALID and DEC all hold.
  - In RUN with INF_VALID=1: HOLD_IR <= IMEM_DATA; state <= HOLD.
  - In HOLD: HOLD_IR holds.
  - In RUN with INF_VALID=0: stay in RUN.
- IF_FLUSH: INF_VALID <= 0 and state <= RUN, overriding the updates above. When DEC advances, it loads a bubble instead of src_ir. A new fetch issued in the same cycle by REDIRECT is not squashed: INF_VALID <= 1 for the target.
- DEC_FLUSH: DEC_VALID <= 0, DEC_IR <= 32'h0000_0013 (NOP), DEC_PC <= 0. Overrides both stall-hold and advance.
- Bubble encoding: DEC_VALID=0 always coincides with DEC_IR=32'h0000_0013 and DEC_PC=0.
- PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- BUBBLE_CNT: increments on each rising edge where DEC_VALID=0 and RST=0. Holds at 2^BUB_W-1.

## Timing
- Reset values, one cycle after RST sampled high:
  - PC=RESET_PC; INF_VALID=0; INF_PC=0; HOLD_IR=0; state=RUN
  - DEC_IR=32'h0000_0013; DEC_PC=0; DEC_VALID=0; BUBBLE_CNT=0
  - During RST: IMEM_RDEN=0, IMEM_ADDR=PC.
- Reset mid-stall or mid-HOLD: all state returns to reset values; the held instruction is discarded.
- First fetch: issued in the first cycle with RST=0 (cycle n). DEC_VALID=1 with DEC_PC=RESET_PC is visible from cycle n+2.
- Fetch-to-decode latency: 2 cycles (issue in n, IMEM returns in n+1, DEC registered at the end of n+1).
- Redirect in cycle n: target appears in DEC from cycle n+2. Wrong-path fetches are removed only by the accompanying flushes.
- Stall lasting k cycles: DEC is frozen for k cycles. The instruction after it reaches DEC on the edge ending the first non-stall cycle. No IMEM re-read is issued.
- LW_STALL and DEC_FLUSH together (load-use bubble into EX is handled downstream): DEC is cleared, PC holds.

## Test plan
- Reset release, no hazards, IMEM returns {addr} as data -> DEC_PC = 0,4,8,... from the 2nd cycle after release; DEC_VALID=1; BUBBLE_CNT ends at 2.
- LW_STALL for 3 cycles while PC=0x10 is in flight -> DEC holds PC 0x0C for 3 cycles, then shows 0x10, then 0x14; IMEM_RDEN=0 for exactly 3 cycles; no duplicate or missing PC.
- REDIRECT to 0x200 with IF_FLUSH and DEC_FLUSH -> next DEC_VALID=0, then DEC_PC=0x200, then 0x204; REDIRECT_PC=0x203 behaves as 0x200.
- REDIRECT, LW_STALL and IF_FLUSH in the same cycle while in HOLD -> redirect wins, HOLD_IR is discarded, DEC_PC=target two cycles later.
- RST asserted during HOLD -> all outputs at reset values next cycle; first fetch after release is RESET_PC.
- PC=0xFFFF_FFFC, advance -> next fetch address 0x0000_0000; BUBBLE_CNT with BUB_W=2 saturates at 3.
